// File: rtl/divider_pkg.sv
// Shared types and constants for the signed divider output stage.
// Contents:
//   DIV_W, DIV_LATENCY, DIV_RES_DEPTH  - datapath width, pipeline depth, result buffer depth
//   DIV0_QUOTIENT                      - quotient reported for a zero divisor
//   div_result_t                       - one corrected result as held in the result FIFO
//   div_token_t                        - issue token travelling beside the divider pipeline
//   twos_neg()                         - modulo-2^W negation used for sign correction
package divider_pkg;

  localparam int DIV_W         = 8;
  localparam int DIV_LATENCY   = 9;
  localparam int DIV_RES_DEPTH = 4;

  localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef struct packed {
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;
    logic             div0;
  } div_result_t;

  typedef struct packed {
    logic valid;
    logic div0;
  } div_token_t;

  // Two's complement negation; wraps modulo 2^W so -(-128) stays 8'h80.
  function automatic logic [DIV_W-1:0] twos_neg(input logic [DIV_W-1:0] v);
    return ~v + {{(DIV_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/divider_result_module_if.sv
// Result channel of the divider output stage: show-ahead valid/ready handshake.
// Signals:
//   out_valid  - head of the result buffer holds a result
//   out_ready  - consumer accepts the head this cycle
//   quotient   - signed quotient of the head result
//   remainder  - signed remainder of the head result
//   div0       - head result came from a zero divisor
// Modports: master = producer (the output stage), slave = consumer.
interface divider_result_module_if #(
  parameter int W = 8
);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div0;

  modport master (
    output out_valid,
    output quotient,
    output remainder,
    output div0,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div0,
    output out_ready
  );

endinterface

// File: rtl/divider_result_fifo.sv
// Show-ahead FIFO of corrected divider results.
// Ports:
//   clk, rst_n - clock and synchronous active-high reset
//   push       - write wr_data at the end of this cycle (ignored when full)
//   wr_data    - result to write
//   pop        - discard the head at the end of this cycle (ignored when empty)
//   head       - current head entry, valid whenever empty is low
//   full       - all DEPTH entries occupied
//   empty      - no entries held
// A push and a pop in the same cycle are both honoured.
module divider_result_fifo
  import divider_pkg::*;
#(
  parameter int DEPTH = DIV_RES_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  div_result_t wr_data,
  input  logic        pop,
  output div_result_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  div_result_t   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/divider_result_module.sv
// Output stage of the 8-bit pipelined signed divider.
// Carries an issue token beside the divider pipeline, sign-corrects the stage-8
// raw magnitudes, buffers results in a show-ahead FIFO and back-pressures the
// issuer with a credit counter so the non-stallable pipeline always finds room.
// Ports:
//   clk, rst_n     - clock and synchronous active-high reset
//   issue_valid    - operands presented to the divider this cycle
//   issue_div0     - divisor of this issue is zero
//   issue_ready    - an accepted issue is guaranteed a FIFO slot
//   q_raw, rem_raw - stage-8 quotient / remainder magnitudes
//   sign_in        - stage-8 sign tags {dividend negative, divisor negative}
//   res            - result handshake (out_valid/out_ready/quotient/remainder/div0)
//   overflow       - sticky: an issue was dropped or a result found the FIFO full
//   clr_overflow   - clears overflow (a simultaneous set wins)
module divider_result_module
  import divider_pkg::*;
#(
  parameter int W       = DIV_W,
  parameter int LATENCY = DIV_LATENCY,
  parameter int DEPTH   = DIV_RES_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_valid,
  input  logic                            issue_div0,
  output logic                            issue_ready,
  input  logic [W-1:0]                    q_raw,
  input  logic [W-1:0]                    rem_raw,
  input  logic [1:0]                      sign_in,
  divider_result_module_if.master         res,
  output logic                            overflow,
  input  logic                            clr_overflow
);

  localparam int CW = $clog2(DEPTH + 1);

  div_token_t    tok_r [LATENCY];
  div_token_t    arrive_s;
  logic [CW-1:0] credits_r;
  logic          acc_s;
  logic          pop_s;
  logic          drop_s;
  logic          wr_full_s;
  logic          overflow_r;
  div_result_t   wr_data_s;
  div_result_t   head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;

  assign issue_ready = (credits_r < CW'(DEPTH));
  assign acc_s       = issue_valid & issue_ready;
  assign drop_s      = issue_valid & ~issue_ready;
  assign arrive_s    = tok_r[LATENCY-1];
  assign pop_s       = res.out_valid & res.out_ready;
  assign wr_full_s   = arrive_s.valid & fifo_full_s;
  assign overflow    = overflow_r;

  assign res.out_valid = ~fifo_empty_s;
  assign res.quotient  = head_s.quotient;
  assign res.remainder = head_s.remainder;
  assign res.div0      = head_s.div0;

  // Token shift register: the last tap lines up with stage-8 divider data.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tok_r[i] <= '0;
      end
    end else begin
      tok_r[0] <= '{valid: acc_s, div0: issue_div0 & acc_s};
      for (int i = 1; i < LATENCY; i++) begin
        tok_r[i] <= tok_r[i-1];
      end
    end
  end

  // Sign correction: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    wr_data_s = '0;
    if (arrive_s.div0) begin
      wr_data_s.quotient  = DIV0_QUOTIENT;
      wr_data_s.remainder = {W{1'b0}};
      wr_data_s.div0      = 1'b1;
    end else begin
      wr_data_s.quotient  = (sign_in[1] ^ sign_in[0]) ? twos_neg(q_raw) : q_raw;
      wr_data_s.remainder = sign_in[1] ? twos_neg(rem_raw) : rem_raw;
      wr_data_s.div0      = 1'b0;
    end
  end

  // Credits count buffered plus in-flight results; accept and pop together cancel.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      credits_r <= '0;
    end else begin
      case ({acc_s, pop_s})
        2'b10:   credits_r <= credits_r + CW'(1);
        2'b01:   credits_r <= credits_r - CW'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  // Sticky error flag; a new error in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s | wr_full_s) begin
      overflow_r <= 1'b1;
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  divider_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (arrive_s.valid),
    .wr_data (wr_data_s),
    .pop     (pop_s),
    .head    (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

endmodule

// File: tb/tb_divider_result_module.sv
// Self-checking bench for divider_result_module: a divider delay-line model feeds
// stage-8 raw data, a queue-based reference computes results with signed integer
// arithmetic, and directed vectors pin latency and hand-computed values.
module tb_divider_result_module;
  import divider_pkg::*;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       d0;
    int         vis;
  } exp_t;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic [1:0] s;
  } raw_t;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b1;
  logic       issue_valid  = 1'b0;
  logic       issue_div0   = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       issue_ready;
  logic       overflow;
  logic [7:0] q_raw;
  logic [7:0] rem_raw;
  logic [1:0] sign_in;

  raw_t cur_raw = {8'hA5, 8'h5A, 2'b11};
  int   cur_a   = 0;
  int   cur_b   = 1;
  raw_t pipe [9];
  exp_t model_q [$];
  logic model_ovf = 1'b0;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  bit   checking  = 1'b0;

  divider_result_module_if #(.W(8)) res_if ();

  divider_result_module #(
    .W       (8),
    .LATENCY (9),
    .DEPTH   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_div0   (issue_div0),
    .issue_ready  (issue_ready),
    .q_raw        (q_raw),
    .rem_raw      (rem_raw),
    .sign_in      (sign_in),
    .res          (res_if),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // Divider pipeline stand-in: raw results appear nine edges after the operands.
  always @(posedge clk) begin
    pipe[0] <= cur_raw;
    for (int i = 1; i < 9; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign q_raw   = pipe[8].q;
  assign rem_raw = pipe[8].r;
  assign sign_in = pipe[8].s;

  function automatic exp_t mk_exp(input int a, input int b, input logic z, input int vis);
    exp_t e;
    int   qq;
    int   rr;
    e.vis = vis;
    if (z) begin
      e.q  = 8'hFF;
      e.r  = 8'h00;
      e.d0 = 1'b1;
    end else begin
      qq   = a / b;
      rr   = a % b;
      e.q  = qq[7:0];
      e.r  = rr[7:0];
      e.d0 = 1'b0;
    end
    return e;
  endfunction

  // Reference: the queue holds every accepted issue, so its size is the credit count.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      model_q.delete();
      model_ovf <= 1'b0;
    end else begin
      if (issue_valid && model_q.size() >= 4) model_ovf <= 1'b1;
      else if (clr_overflow) model_ovf <= 1'b0;
      if (issue_valid && model_q.size() < 4)
        model_q.push_back(mk_exp(cur_a, cur_b, issue_div0, cyc + 10));
      if (model_q.size() > 0 && model_q[0].vis <= cyc && res_if.out_ready)
        void'(model_q.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("issue_ready", {31'b0, issue_ready}, (model_q.size() < 4) ? 32'd1 : 32'd0);
      check("overflow", {31'b0, overflow}, {31'b0, model_ovf});
      if (model_q.size() > 0 && model_q[0].vis <= cyc) begin
        check("out_valid", {31'b0, res_if.out_valid}, 32'd1);
        check("quotient", {24'b0, res_if.quotient}, {24'b0, model_q[0].q});
        check("remainder", {24'b0, res_if.remainder}, {24'b0, model_q[0].r});
        check("div0", {31'b0, res_if.div0}, {31'b0, model_q[0].d0});
      end else begin
        check("out_valid", {31'b0, res_if.out_valid}, 32'd0);
      end
    end
  end

  task automatic issue(input int a, input int b, input bit z);
    int aa;
    int bb;
    cur_a       = a;
    cur_b       = b;
    issue_valid = 1'b1;
    issue_div0  = z;
    if (z) begin
      cur_raw = {8'h3C, 8'hC3, 2'b11};
    end else begin
      aa        = (a < 0) ? -a : a;
      bb        = (b < 0) ? -b : b;
      cur_raw.q = 8'(aa / bb);
      cur_raw.r = 8'(aa % bb);
      cur_raw.s = {a < 0, b < 0};
    end
    @(negedge clk);
    issue_valid = 1'b0;
    issue_div0  = 1'b0;
    cur_raw     = {8'hA5, 8'h5A, 2'b11};
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One isolated issue: result absent at 9 edges, present at 10, then popped.
  task automatic single(input int a, input int b, input bit z,
                        input logic [7:0] eq, input logic [7:0] er, input logic ed);
    res_if.out_ready = 1'b0;
    issue(a, b, z);
    idle(8);
    check("latency_not_early", {31'b0, res_if.out_valid}, 32'd0);
    idle(1);
    check("latency_valid", {31'b0, res_if.out_valid}, 32'd1);
    check("lit_quotient", {24'b0, res_if.quotient}, {24'b0, eq});
    check("lit_remainder", {24'b0, res_if.remainder}, {24'b0, er});
    check("lit_div0", {31'b0, res_if.div0}, {31'b0, ed});
    res_if.out_ready = 1'b1;
    idle(1);
    res_if.out_ready = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", {31'b0, res_if.out_valid}, 32'd0);
    check("rst_quotient", {24'b0, res_if.quotient}, 32'd0);
    check("rst_remainder", {24'b0, res_if.remainder}, 32'd0);
    check("rst_div0", {31'b0, res_if.div0}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
  endtask

  initial begin
    res_if.out_ready = 1'b0;
    idle(3);
    rst_n    = 1'b0;
    checking = 1'b1;
    idle(1);
    check_reset_state();

    // Hand-computed sign-correction and zero-divisor vectors.
    single(100, 7, 1'b0, 8'h0E, 8'h02, 1'b0);
    single(-100, 7, 1'b0, 8'hF2, 8'hFE, 1'b0);
    single(100, -7, 1'b0, 8'hF2, 8'h02, 1'b0);
    single(37, 0, 1'b1, 8'hFF, 8'h00, 1'b1);
    single(-128, -1, 1'b0, 8'h80, 8'h00, 1'b0);

    // Back-to-back stream drained continuously.
    res_if.out_ready = 1'b1;
    issue(-7, 2, 1'b0);
    issue(-100, -7, 1'b0);
    issue(127, 1, 1'b0);
    issue(-1, 0, 1'b1);
    issue(-128, 3, 1'b0);
    idle(12);

    // Back-pressure: four accepted, two dropped, drained in order.
    res_if.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(10 * i + 1, 3, 1'b0);
      if (i == 3) check("ready_low_after_4th", {31'b0, issue_ready}, 32'd0);
    end
    check("overflow_after_drops", {31'b0, overflow}, 32'd1);
    idle(12);
    res_if.out_ready = 1'b1;
    idle(6);
    res_if.out_ready = 1'b0;
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("overflow_cleared", {31'b0, overflow}, 32'd0);

    // Three buffered entries, then issue and pop together.
    issue(50, 5, 1'b0);
    issue(-50, 6, 1'b0);
    issue(50, -9, 1'b0);
    idle(12);
    res_if.out_ready = 1'b1;
    issue(99, 4, 1'b0);
    res_if.out_ready = 1'b0;
    check("ready_after_issue_pop", {31'b0, issue_ready}, 32'd1);
    issue(-99, -4, 1'b0);
    check("ready_low_at_4_credits", {31'b0, issue_ready}, 32'd0);
    idle(12);
    res_if.out_ready = 1'b1;
    idle(8);
    check("no_drop_overflow", {31'b0, overflow}, 32'd0);

    // Reset with three results in flight: none may surface.
    issue(11, 2, 1'b0);
    issue(12, 2, 1'b0);
    issue(13, 2, 1'b0);
    idle(5);
    rst_n = 1'b1;
    idle(1);
    rst_n = 1'b0;
    check_reset_state();
    idle(14);
    check("post_reset_no_valid", {31'b0, res_if.out_valid}, 32'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_result_module.md
# divider_result_module

Output stage placed directly downstream of the 8-bit pipelined signed divider. It carries an issue-valid token alongside the divider's 9-register datapath and applies sign correction to the stage-8 raw quotient and remainder magnitudes. It buffers corrected results in a small show-ahead FIFO with a valid/ready output handshake. A credit counter back-pressures the issuer, so the non-stallable divider pipeline never delivers a result with no FIFO space for it.

## Interface
- `W`, 8: operand and result width.
- `LATENCY`, 9: register stages from divider input to stage-8 outputs.
- `DEPTH`, 4: result FIFO depth; power of two, at least 2.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-high (asserted = 1).
- `issue_valid`  in  1  dividend/divisor presented to the divider this cycle.
- `issue_div0`  in  1  divisor == 0 for this issue; sampled with `issue_valid`.
- `issue_ready`  out  1  an accepted issue is guaranteed FIFO space.
- `q_raw`  in  W  stage-8 unsigned quotient bits.
- `rem_raw`  in  W  stage-8 remainder magnitude.
- `sign_in`  in  2  stage-8 sign tags: bit1 = dividend negative, bit0 = divisor negative.
- `out_valid`  out  1  FIFO head holds a result.
- `out_ready`  in  1  consumer accepts the head.
- `quotient`  out  W  signed quotient at the FIFO head.
- `remainder`  out  W  signed remainder at the FIFO head.
- `div0`  out  1  head result came from a zero divisor.
- `overflow`  out  1  sticky error flag.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- Issue accept: `acc = issue_valid & issue_ready`. A token `{acc, issue_div0}` enters a LATENCY-deep shift register.
- Dropped issue: `issue_valid & !issue_ready` sets `overflow`. No token is injected, and the divider's result for that issue is ignored.
- Arrival: the token at shift-register tap LATENCY-1 lines up with stage-8 data that cycle.
- Write: when the arriving token is valid, the corrected result is written to the FIFO at the end of that cycle.
- Quotient correction: quotient = `sign_in[1]^sign_in[0]` ? two's complement of `q_raw` : `q_raw`.
- Remainder correction: remainder = `sign_in[1]` ? two's complement of `rem_raw` : `rem_raw`. The remainder takes the dividend's sign.
- Divide by zero: if the token's div0 is set, write quotient 8'hFF, remainder 8'h00, div0 = 1, ignoring the raw inputs.
- Arithmetic: all modulo 2^W. -128 / -1 yields 8'h80 with no flag.
- Credits: `credits` (0..DEPTH) counts FIFO entries plus in-flight tokens.
  - +1 on `acc`; -1 on `out_valid & out_ready`; both in one cycle leaves it unchanged.
  - `issue_ready = (credits < DEPTH)`, combinational from the register.
- FIFO is show-ahead: the head drives `quotient`, `remainder`, `div0`; `out_valid = !empty`. A pop and a push in the same cycle are both honoured.
- Write to a full FIFO: cannot occur when credits are respected. If it does occur, the result is dropped and `overflow` is set; the bench asserts this never happens.
- `overflow`: sets on either event above. `clr_overflow` clears it; a simultaneous set wins.

## Timing
- Values after reset:
  - `out_valid` = 0, `quotient` = 0, `remainder` = 0, `div0` = 0.
  - `overflow` = 0, `issue_ready` = 1, `credits` = 0.
  - Token shift register all 0; FIFO empty.
- Latency: accept at edge k; FIFO write at edge k+LATENCY. `out_valid` is high from cycle k+LATENCY+1 if the FIFO was empty. Issue-to-output latency is LATENCY+1 = 10 cycles.
- Throughput: one issue per cycle while `issue_ready` = 1.
- Output handshake: data and `out_valid` stay stable while `out_valid & !out_ready`.
- Credits at DEPTH: `issue_ready` falls the cycle after the DEPTH-th accept and rises the cycle after a pop.
- Reset mid-operation: flushes tokens, FIFO and credits. The divider pipeline is not flushed, but its stale data is never written because no tokens survive.

## Structure
- Package `divider_pkg`: constants `DIV_W`, `DIV_LATENCY`, `DIV_RES_DEPTH`, `DIV0_QUOTIENT` (8'hFF); function `twos_neg`; packed struct `div_result_t {quotient, remainder, div0}`.
- One sub-module, `divider_result_fifo`: a DEPTH-entry show-ahead FIFO of `div_result_t` with push/pop/full/empty.
- The token shift register, sign correction and credit counter stay in the top module.

## Test plan
- 100 / 7 (sign_in 2'b00, q_raw 14, rem_raw 2) -> quotient 8'h0E, remainder 8'h02, div0 0, `out_valid` 10 cycles after issue.
- -100 / 7 (sign_in 2'b10, q_raw 14, rem_raw 2) -> quotient 8'hF2, remainder 8'hFE. 100 / -7 (sign_in 2'b01) -> quotient 8'hF2, remainder 8'h02.
- Divisor 0 with `issue_div0` = 1 and arbitrary raw inputs -> quotient 8'hFF, remainder 8'h00, div0 1.
- `out_ready` = 0 with 6 back-to-back issues:
  - 4 are accepted; `issue_ready` is 0 from the cycle after the 4th.
  - Issues 5 and 6 set `overflow`.
  - Raising `out_ready` drains 4 results in issue order.
- FIFO steady at 3 entries; issue and pop in the same cycle -> `credits` unchanged, `issue_ready` stays 1, no dropped result.
- Reset asserted 5 cycles after 3 issues -> `out_valid` never rises for those issues; all outputs at reset values the cycle after reset.
